// File: rtl/logic_gate_tester_if.sv
// Stimulus/result bundle between the gate self-tester and the gate block plus its observer.
interface logic_gate_tester_if;
    logic       start;
    logic [7:0] gates_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] fail_mask;
    logic [2:0] err_count;

    modport master (
        output start, gates_in,
        input  a_out, b_out, busy, done, pass, fail_mask, err_count
    );

    modport slave (
        input  start, gates_in,
        output a_out, b_out, busy, done, pass, fail_mask, err_count
    );
endinterface

// File: rtl/logic_gate_tester.sv
// Self-timed exerciser for a two-input gate block: walks A/B through 00,01,10,11, samples the eight
// gate outputs after a settle window and records sticky per-gate mismatches. SETTLE_CYCLES legal range 1..15.
module logic_gate_tester #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    logic_gate_tester_if.slave    bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned VEC_W  = 2;
    localparam int unsigned GATE_W = 8;
    localparam int unsigned ERR_W  = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(3);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t             state;
    logic [VEC_W-1:0]   vec;
    logic [CNT_W-1:0]   cnt;
    logic               a_q;
    logic               b_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [GATE_W-1:0]  fail_mask_q;
    logic [ERR_W-1:0]   err_count_q;
    logic [GATE_W-1:0]  exp_gates;
    logic [GATE_W-1:0]  mism;

    // Reference gate outputs for the vector currently driven; vec[1] is A, vec[0] is B.
    assign exp_gates = {~(vec[1] ^ vec[0]), vec[1] ^ vec[0],
                        ~(vec[1] | vec[0]), vec[1] | vec[0],
                        ~(vec[1] & vec[0]), vec[1] & vec[0],
                        ~vec[1],            vec[1]};
    assign mism = bus.gates_in ^ exp_gates;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vec         <= '0;
            cnt         <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            err_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= SETTLE;
                        vec         <= '0;
                        {a_q, b_q}  <= 2'b00;
                        cnt         <= CNT_LOAD;
                        fail_mask_q <= '0;
                        err_count_q <= '0;
                        pass_q      <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    fail_mask_q <= fail_mask_q | mism;
                    if (|mism) begin
                        err_count_q <= err_count_q + ERR_W'(1);
                    end
                    if (vec != VEC_LAST) begin
                        vec        <= vec + VEC_W'(1);
                        {a_q, b_q} <= vec + VEC_W'(1);
                        cnt        <= CNT_LOAD;
                        state      <= SETTLE;
                    end else begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= ~|(fail_mask_q | mism);
                    end
                end
                DONE: begin
                    // Start is deliberately not looked at here; the run is already complete.
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_out     = a_q;
    assign bus.b_out     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_mask_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_logic_gate_tester.sv
// Bench for logic_gate_tester: emulated gate block with injectable faults, checked against a vector-level model.
module tb_logic_gate_tester;
    typedef struct packed {
        logic       done;
        logic       busy;
        logic       a;
        logic       b;
        logic       pass;
        logic [7:0] fm;
        logic [2:0] ec;
    } obs_t;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic [7:0] glitch_v [3];
    logic [7:0] sa0;
    logic [7:0] sa1;
    logic       swp;
    int         total = 0;
    int         bad   = 0;
    obs_t       trace [$];

    logic_gate_tester_if if_s2 ();
    logic_gate_tester_if if_s1 ();
    logic_gate_tester_if if_s15 ();

    logic_gate_tester #(.SETTLE_CYCLES(2))  dut_s2  (.clk(clk), .rst(rst), .bus(if_s2));
    logic_gate_tester #(.SETTLE_CYCLES(1))  dut_s1  (.clk(clk), .rst(rst), .bus(if_s1));
    logic_gate_tester #(.SETTLE_CYCLES(15)) dut_s15 (.clk(clk), .rst(rst), .bus(if_s15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table of a healthy gate block, from the arithmetic meaning of each gate.
    function automatic logic [7:0] good(input int a, input int b);
        logic [7:0] r;
        int s;
        s = a + b;
        r[0] = (a != 0);
        r[1] = (a == 0);
        r[2] = ((a * b) != 0);
        r[3] = ((a * b) == 0);
        r[4] = (s > 0);
        r[5] = (s == 0);
        r[6] = (s == 1);
        r[7] = (s != 1);
        return r;
    endfunction

    function automatic logic [7:0] faulty(input logic a, input logic b, input logic [7:0] s0,
                                          input logic [7:0] s1, input logic sw);
        logic [7:0] g;
        g = good(int'(a), int'(b));
        g = (g & ~s0) | s1;
        if (sw) g = {g[6], g[7], g[5:0]};
        return g;
    endfunction

    assign if_s2.start     = start_v[0];
    assign if_s1.start     = start_v[1];
    assign if_s15.start    = start_v[2];
    assign if_s2.gates_in  = faulty(if_s2.a_out,  if_s2.b_out,  sa0, sa1, swp) ^ glitch_v[0];
    assign if_s1.gates_in  = faulty(if_s1.a_out,  if_s1.b_out,  sa0, sa1, swp) ^ glitch_v[1];
    assign if_s15.gates_in = faulty(if_s15.a_out, if_s15.b_out, sa0, sa1, swp) ^ glitch_v[2];

    // Expected run results: walk the four vectors and compare faulty vs healthy outputs.
    task automatic model(input logic [7:0] s0, input logic [7:0] s1, input logic sw,
                         output logic [7:0] fm, output int ec);
        fm = '0;
        ec = 0;
        for (int v = 0; v < 4; v++) begin
            logic [7:0] m;
            m = faulty(1'(v / 2), 1'(v % 2), s0, s1, sw) ^ good(v / 2, v % 2);
            fm = fm | m;
            if (m != 8'h00) ec++;
        end
    endtask

    function automatic obs_t obs(input int idx);
        obs_t o;
        o = '0;
        case (idx)
            0: o = '{if_s2.done, if_s2.busy, if_s2.a_out, if_s2.b_out, if_s2.pass,
                     if_s2.fail_mask, if_s2.err_count};
            1: o = '{if_s1.done, if_s1.busy, if_s1.a_out, if_s1.b_out, if_s1.pass,
                     if_s1.fail_mask, if_s1.err_count};
            2: o = '{if_s15.done, if_s15.busy, if_s15.a_out, if_s15.b_out, if_s15.pass,
                     if_s15.fail_mask, if_s15.err_count};
            default: o = '0;
        endcase
        return o;
    endfunction

    // Pulse Start, then record one observation per cycle; trace[c] is taken just after edge E0+c.
    task automatic run(input int idx, input int s, input logic [63:0] pulse, input int rst_at,
                       input bit glitch_en, output int done_k, output int ndone);
        int ncyc;
        ncyc = 4 * (s + 1) + 3;
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
        trace.delete();
        trace.push_back(obs(idx));
        done_k = -1;
        ndone  = 0;
        for (int c = 0; c < ncyc; c++) begin
            start_v[idx]  = (c < 64) ? pulse[c[5:0]] : 1'b0;
            rst           = (c == rst_at);
            glitch_v[idx] = (glitch_en && ((c % (s + 1)) != s)) ? 8'hFF : 8'h00;
            @(posedge clk);
            #1;
            trace.push_back(obs(idx));
            if (trace[c + 1].done) begin
                ndone++;
                if (done_k < 0) done_k = c + 1;
            end
        end
        start_v[idx]  = 1'b0;
        rst           = 1'b0;
        glitch_v[idx] = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs(i) !== obs_t'(0)) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got %h want 0", i, obs(i));
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_good_run();
        int dk;
        int nd;
        sa0 = 8'h00; sa1 = 8'h00; swp = 1'b0;
        run(0, 2, 64'd0, -1, 1'b0, dk, nd);
        total++;
        if (dk !== 12) begin bad++; $display("FAIL good_done_cycle: got %0d want 12", dk); end
        total++;
        if (nd !== 1) begin bad++; $display("FAIL good_done_pulses: got %0d want 1", nd); end
        for (int c = 0; c < 12; c++) begin
            total++;
            if (trace[c].busy !== 1'b1 || {trace[c].a, trace[c].b} !== 2'(c / 3)) begin
                bad++;
                $display("FAIL good_stimulus[%0d]: got busy=%b ab=%b want busy=1 ab=%b",
                         c, trace[c].busy, {trace[c].a, trace[c].b}, 2'(c / 3));
            end
        end
        total++;
        if (trace[12].busy !== 1'b0 || trace[12].pass !== 1'b1 || trace[12].fm !== 8'h00 ||
            trace[12].ec !== 3'd0) begin
            bad++;
            $display("FAIL good_result: got busy=%b pass=%b fm=%h ec=%0d want 0 1 00 0",
                     trace[12].busy, trace[12].pass, trace[12].fm, trace[12].ec);
        end
        total++;
        if (trace[13].done !== 1'b0) begin bad++; $display("FAIL good_done_width: got 1 want 0"); end
    endtask

    task automatic test_faults();
        int dk;
        int nd;
        int ec_exp;
        logic [7:0] fm_exp;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0: begin sa0 = 8'h08; sa1 = 8'h00; swp = 1'b0; end
                1: begin sa0 = 8'h00; sa1 = 8'h00; swp = 1'b1; end
                2: begin sa0 = 8'h00; sa1 = 8'h01; swp = 1'b0; end
                default: begin sa0 = 8'($urandom); sa1 = 8'($urandom) & 8'($urandom); swp = 1'($urandom); end
            endcase
            model(sa0, sa1, swp, fm_exp, ec_exp);
            run(0, 2, 64'd0, -1, 1'b0, dk, nd);
            total++;
            if (dk !== 12 || trace[12].fm !== fm_exp || trace[12].ec !== 3'(ec_exp) ||
                trace[12].pass !== (fm_exp == 8'h00)) begin
                bad++;
                $display("FAIL fault_run[%0d]: got done@%0d fm=%h ec=%0d pass=%b want done@12 fm=%h ec=%0d pass=%b",
                         i, dk, trace[12].fm, trace[12].ec, trace[12].pass, fm_exp, ec_exp, fm_exp == 8'h00);
            end
        end
        sa0 = 8'h00; sa1 = 8'h00; swp = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dk;
        int nd;
        logic [63:0] pulse;
        pulse = '0;
        pulse[3] = 1'b1; pulse[7] = 1'b1; pulse[12] = 1'b1;
        sa0 = 8'h08;
        run(0, 2, pulse, -1, 1'b0, dk, nd);
        total++;
        if (dk !== 12 || nd !== 1) begin
            bad++;
            $display("FAIL b2b_single_run: got done@%0d pulses=%0d want done@12 pulses=1", dk, nd);
        end
        total++;
        if (trace[15].fm !== 8'h08 || trace[15].ec !== 3'd3 || trace[15].pass !== 1'b0 ||
            trace[15].busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_results: got fm=%h ec=%0d pass=%b busy=%b want 08 3 0 0",
                     trace[15].fm, trace[15].ec, trace[15].pass, trace[15].busy);
        end
        sa0 = 8'h00;
        run(0, 2, 64'd0, -1, 1'b0, dk, nd);
        total++;
        if (trace[0].fm !== 8'h00 || trace[0].ec !== 3'd0 || trace[0].pass !== 1'b0) begin
            bad++;
            $display("FAIL b2b_clear_on_start: got fm=%h ec=%0d pass=%b want 00 0 0",
                     trace[0].fm, trace[0].ec, trace[0].pass);
        end
        total++;
        if (dk !== 12 || trace[12].pass !== 1'b1 || trace[12].fm !== 8'h00) begin
            bad++;
            $display("FAIL b2b_rerun: got done@%0d pass=%b fm=%h want done@12 pass=1 fm=00",
                     dk, trace[12].pass, trace[12].fm);
        end
    endtask

    task automatic test_mid_reset();
        int dk;
        int nd;
        sa0 = 8'h08;
        run(0, 2, 64'd0, 5, 1'b0, dk, nd);
        total++;
        if (trace[5].fm !== 8'h08) begin
            bad++;
            $display("FAIL rst_pre_fm: got %h want 08", trace[5].fm);
        end
        total++;
        if (trace[6] !== obs_t'(0)) begin
            bad++;
            $display("FAIL rst_outputs: got %h want 0", trace[6]);
        end
        total++;
        if (nd !== 0 || trace[15] !== obs_t'(0)) begin
            bad++;
            $display("FAIL rst_no_done: got pulses=%0d final=%h want 0 0", nd, trace[15]);
        end
        sa0 = 8'h00;
        run(0, 2, 64'd0, -1, 1'b0, dk, nd);
        total++;
        if (dk !== 12 || trace[12].pass !== 1'b1 || trace[12].fm !== 8'h00 || trace[12].ec !== 3'd0) begin
            bad++;
            $display("FAIL rst_recovery: got done@%0d pass=%b fm=%h ec=%0d want done@12 1 00 0",
                     dk, trace[12].pass, trace[12].fm, trace[12].ec);
        end
    endtask

    task automatic test_settle_params();
        int dk;
        int nd;
        int s;
        int last;
        for (int k = 1; k < 3; k++) begin
            s = (k == 1) ? 1 : 15;
            last = 4 * (s + 1);
            run(k, s, 64'd0, -1, 1'b1, dk, nd);
            total++;
            if (dk !== last || nd !== 1) begin
                bad++;
                $display("FAIL settle%0d_done: got done@%0d pulses=%0d want done@%0d pulses=1", s, dk, nd, last);
            end
            for (int c = 0; c < last; c += s + 1) begin
                total++;
                if ({trace[c].a, trace[c].b} !== 2'(c / (s + 1)) || trace[c].busy !== 1'b1) begin
                    bad++;
                    $display("FAIL settle%0d_stimulus[%0d]: got ab=%b busy=%b want ab=%b busy=1",
                             s, c, {trace[c].a, trace[c].b}, trace[c].busy, 2'(c / (s + 1)));
                end
            end
            total++;
            if (trace[last].pass !== 1'b1 || trace[last].fm !== 8'h00 || trace[last].ec !== 3'd0) begin
                bad++;
                $display("FAIL settle%0d_glitch_immune: got pass=%b fm=%h ec=%0d want 1 00 0",
                         s, trace[last].pass, trace[last].fm, trace[last].ec);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start_v = '0;
        sa0 = 8'h00;
        sa1 = 8'h00;
        swp = 1'b0;
        for (int i = 0; i < 3; i++) glitch_v[i] = 8'h00;
        test_reset();
        test_good_run();
        test_faults();
        test_back_to_back();
        test_mid_reset();
        test_settle_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
